// File: rtl/sum_accumulator_10bits_if.sv
// Operand and result handshake bundle for the sum accumulator.
// The accumulator connects through the slave modport; the producer and consumer side uses master.
interface sum_accumulator_10bits_if #(
    parameter int IN_W  = 10,
    parameter int ACC_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_sum;
    logic             in_carry;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_acc;
    logic             out_sat;

    modport master (
        output in_valid, in_sum, in_carry, out_ready,
        input  in_ready, out_valid, out_acc, out_sat
    );

    modport slave (
        input  in_valid, in_sum, in_carry, out_ready,
        output in_ready, out_valid, out_acc, out_sat
    );
endinterface

// File: rtl/sum_accumulator_10bits.sv
// Sums N_SAMPLES adder results ({carry, sum}) into a saturating accumulator and
// presents each frame total on a valid/ready output.
module sum_accumulator_10bits #(
    parameter int IN_W      = 10,
    parameter int ACC_W     = 16,
    parameter int N_SAMPLES = 8,
    parameter int CNT_W     = 4
) (
    input logic                    clk,
    input logic                    reset,
    sum_accumulator_10bits_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DONE
    } state_t;

    state_t             state;
    logic [ACC_W-1:0]   acc;
    logic               sat;
    logic [CNT_W-1:0]   cnt;

    logic [ACC_W:0]     op_ext;
    logic [ACC_W:0]     sum;
    logic               xfer;

    assign op_ext = {{(ACC_W - IN_W){1'b0}}, bus.in_carry, bus.in_sum};
    assign sum    = {1'b0, acc} + op_ext;
    assign xfer   = bus.in_valid && bus.in_ready;

    // Outputs come straight from registers or the state decode, so neither
    // in_valid nor out_ready has a combinational path to any output.
    assign bus.in_ready  = (state != DONE);
    assign bus.out_valid = (state == DONE);
    assign bus.out_acc   = acc;
    assign bus.out_sat   = sat;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            acc   <= '0;
            sat   <= 1'b0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (xfer) begin
                        acc   <= op_ext[ACC_W-1:0];
                        sat   <= 1'b0;
                        cnt   <= CNT_W'(1);
                        state <= (N_SAMPLES == 1) ? DONE : ACCUM;
                    end
                end
                ACCUM: begin
                    if (xfer) begin
                        if (sum[ACC_W]) begin
                            acc <= '1;
                            sat <= 1'b1;
                        end else begin
                            acc <= sum[ACC_W-1:0];
                        end
                        cnt <= cnt + CNT_W'(1);
                        if (cnt == CNT_W'(N_SAMPLES - 1)) begin
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        cnt   <= '0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
